// File: rtl/muldiv_alu_sequencer.sv
// Multi-cycle MUL / DIVU / REMU controller that iterates through the shared ALU add/subtract path.
// Optional early termination is enabled with the MULDIV_EARLY_OUT_EN macro.
module muldiv_alu_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_ult
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] alu_a_s, alu_b_s;
  logic [3:0]      alu_op_s;
  logic [XLEN-1:0] rs_s;
  logic            ovf_s;
  logic            take_s;
  logic            early_s;

  // Shifted partial remainder; ovf is the bit that falls off the top of rem
  assign rs_s   = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign ovf_s  = rem_q[XLEN-1];
  assign take_s = ovf_s | ~alu_ult;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = ((op_q == OP_MUL) && (mplier_q == {XLEN{1'b0}})) ||
                   (((op_q == OP_DIVU) || (op_q == OP_REMU)) && (dvsr_q == {XLEN{1'b0}}));
`else
  assign early_s = 1'b0;
`endif

  // Next-state, iteration datapath and ALU drive
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    alu_a_s  = {XLEN{1'b0}};
    alu_b_s  = {XLEN{1'b0}};
    alu_op_s = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          op_d     = op;
          cnt_d    = 6'd0;
          acc_d    = {XLEN{1'b0}};
          mcand_d  = rs1;
          mplier_d = rs2;
          rem_d    = {XLEN{1'b0}};
          dvd_d    = rs1;
          dvsr_d   = rs2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        case (op_q)
          OP_MUL: begin
            alu_a_s  = acc_q;
            alu_b_s  = mcand_q;
            alu_op_s = ALU_ADD;
            if (mplier_q[0]) begin
              acc_d = alu_result;
            end else begin
              acc_d = acc_q;
            end
            mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          end
          OP_DIVU, OP_REMU: begin
            alu_a_s  = rs_s;
            alu_b_s  = dvsr_q;
            alu_op_s = ALU_SUB;
            if (take_s) begin
              rem_d = alu_result;
            end else begin
              rem_d = rs_s;
            end
            dvd_d = {dvd_q[XLEN-2:0], take_s};
          end
          default: begin
            alu_op_s = ALU_ADD;
          end
        endcase
        // Reserved op spends a single RUN cycle and returns zero
        if ((cnt_q == 6'd63) || early_s || (op_q == 2'b11)) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:  result_d = acc_d;
            OP_DIVU: result_d = early_s ? {XLEN{1'b1}} : dvd_d;
            OP_REMU: result_d = early_s ? dvd_q : rem_d;
            default: result_d = {XLEN{1'b0}};
          endcase
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      cnt_q    <= 6'd0;
      acc_q    <= {XLEN{1'b0}};
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      dvd_q    <= {XLEN{1'b0}};
      dvsr_q   <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign alu_a  = alu_a_s;
  assign alu_b  = alu_b_s;
  assign alu_op = alu_op_s;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Directed self-checking bench for muldiv_alu_sequencer with a behavioural ALU model.
// Expected latencies follow MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_muldiv_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] rs1, rs2;
  logic        busy, done;
  logic [63:0] result;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_ult;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int L_MUL76  = 5;
  localparam int L_MULX2  = 4;
  localparam int L_MULBIG = 15;
  localparam int L_DIV0   = 2;
`else
  localparam int L_MUL76  = 65;
  localparam int L_MULX2  = 65;
  localparam int L_MULBIG = 65;
  localparam int L_DIV0   = 65;
`endif
  localparam int L_FULL = 65;

  muldiv_alu_sequencer #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_ult(alu_ult)
  );

  // Behavioural shared ALU: add/subtract and unsigned less-than
  always_comb begin
    alu_result = (alu_op == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_ult    = (alu_a < alu_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, track cycles after the accepting edge, optionally poke start mid-run
  task automatic run(input string tag, input logic [1:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat,
                     input int poke);
    int  k;
    bit  seen;
    logic [3:0] exp_op;
    exp_op = (o == 2'b00) ? 4'b0010 : 4'b0110;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && (k < 200)) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        if (o != 2'b11) check({tag, "_aluop"}, {60'd0, alu_op}, {60'd0, exp_op});
        if (k == poke) begin
          start = 1'b1; op = 2'b00; rs1 = 64'd5; rs2 = 64'd5;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_done_alu_a"}, alu_a, 64'd0);
    check({tag, "_done_alu_op"}, {60'd0, alu_op}, 64'd2);
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    check({tag, "_done_fall"}, {63'd0, done}, 64'd0);
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = 64'd0; rs2 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_alu_a",  alu_a, 64'd0);
    check("rst_alu_b",  alu_b, 64'd0);
    check("rst_alu_op", {60'd0, alu_op}, 64'd2);
    reset = 1'b0;

    run("mul_7x6",   2'b00, 64'd7, 64'd6, 64'd42, L_MUL76, 0);
    run("mul_wrap",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, L_MULX2, 0);
    run("mul_big",   2'b00, 64'h1234_5678, 64'h1000, 64'h0000_0123_4567_8000, L_MULBIG, 0);
    run("divu_100_7", 2'b01, 64'd100, 64'd7, 64'd14, L_FULL, 0);
    run("remu_100_7", 2'b10, 64'd100, 64'd7, 64'd2, L_FULL, 0);
    run("divu_ovf",  2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, L_FULL, 0);
    run("remu_ovf",  2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
        64'h7FFF_FFFF_FFFF_FFFE, L_FULL, 0);
    run("divu_by0",  2'b01, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, L_DIV0, 0);
    run("remu_by0",  2'b10, 64'd1234, 64'd0, 64'd1234, L_DIV0, 0);
    run("reserved",  2'b11, 64'd9, 64'd9, 64'd0, 2, 0);
    run("start_ignored", 2'b01, 64'd100, 64'd7, 64'd14, L_FULL, 10);

    // Reset in the middle of a division
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1 = 64'd100; rs2 = 64'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("midrun_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy",   {63'd0, busy}, 64'd0);
    check("midrst_done",   {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_alu_op", {60'd0, alu_op}, 64'd2);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    check("midrst_idle", {63'd0, busy}, 64'd0);

    run("after_reset", 2'b00, 64'd7, 64'd6, 64'd42, L_MUL76, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_alu_sequencer.md
# muldiv_alu_sequencer

Multi-cycle controller that computes 64-bit MUL, DIVU and REMU by driving the shared integer ALU through its add/subtract path, one iteration per cycle. It holds the operand, accumulator and iteration state and presents ALU operands and opcodes each cycle. It consumes the ALU's `result` and `unsigned_lesser` outputs. It sits beside the execute stage and returns a single result with a done pulse.

## Interface
Parameters:
- `XLEN`, 64: datapath width; only 64 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 = MUL (low 64 bits), 01 = DIVU, 10 = REMU, 11 = reserved.
- `rs1`  in  64  multiplicand or dividend; captured when a start is accepted.
- `rs2`  in  64  multiplier or divisor; captured when a start is accepted.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse, asserted in DONE.
- `result`  out  64  final value; held from DONE until the next accepted start.
- `alu_a`  out  64  ALU operand A.
- `alu_b`  out  64  ALU operand B.
- `alu_op`  out  4  ALU opcode: 4'b0010 = add, 4'b0110 = subtract.
- `alu_result`  in  64  ALU result, combinational from `alu_a`, `alu_b` and `alu_op`.
- `alu_ult`  in  1  ALU `unsigned_lesser` output (`alu_a < alu_b`, unsigned).

## Operation
- **States:**
  - IDLE: `start` = 1 moves to RUN, captures operands and `op`, and clears the 6-bit counter `cnt`.
  - RUN: moves to DONE after the iteration with `cnt` = 63, or on an early-out.
  - DONE: lasts one cycle, then returns to IDLE.
- **MUL iteration:**
  - Drive `alu_a` = acc, `alu_b` = mcand, `alu_op` = add.
  - If `mplier[0]` = 1, load acc from `alu_result`.
  - Shift: mcand <<= 1, mplier >>= 1. Wrap mod 2^64; no carry is tracked.
- **DIVU/REMU iteration (restoring):**
  - Form the shifted remainder: `{ovf, rs} = {rem, dvd[63]}`.
  - Drive `alu_a` = rs, `alu_b` = divisor, `alu_op` = subtract.
  - Take the subtract when `ovf` = 1 or `alu_ult` = 0.
  - If taken: rem <= `alu_result` (mod 2^64 is correct when `ovf` = 1) and the quotient bit is 1.
  - Otherwise: rem <= rs and the quotient bit is 0.
  - Update dvd <= {dvd[62:0], qbit}, so dvd becomes the quotient.
- **Final `result`:**
  - MUL: acc.
  - DIVU: quotient.
  - REMU: rem.
- **Division by zero:** quotient = all ones, remainder = `rs1`. This falls out of the algorithm naturally.
- **op = 11:** goes to RUN for exactly one cycle, then DONE with `result` = 0.
- **Idle ALU drive:** in IDLE and DONE, `alu_a` = `alu_b` = 0 and `alu_op` = add.
- **Start while busy:** ignored; captured operands never change during RUN.
- **Start in DONE:** ignored. A new start is accepted only in the following IDLE cycle.
- **Reset at any time, including mid-RUN:** next state IDLE; `busy` = 0, `done` = 0, `result` = 0, all internal registers 0.

## Timing
- Start accepted at edge T (IDLE, `start` = 1).
- RUN occupies the 64 cycles after T; `done` = 1 and `result` is valid in cycle T+65.
- `busy` rises the cycle after T and falls the cycle after `done`.
- Back-to-back throughput: one operation per 66 cycles.
- The ALU path is combinational within one RUN cycle. The controller adds no ALU pipeline stage.
- Reset values: `busy` 0, `done` 0, `result` 0, `alu_a` 0, `alu_b` 0, `alu_op` 4'b0010.

## Configuration
- Macro: `MULDIV_EARLY_OUT_EN`.
- **Defined:**
  - MUL leaves RUN once the remaining multiplier is zero, checked at the start of each RUN cycle (an all-zero multiplier takes one RUN cycle).
  - DIVU/REMU with divisor 0 leave RUN after one cycle with the spec'd results.
  - Latency becomes 2 + iterations, minimum 2 cycles from accept to `done`.
- **Undefined:** every MUL/DIVU/REMU takes exactly 64 RUN cycles. Results are identical in both builds.

## Test plan
- MUL `rs1` = 7, `rs2` = 6 -> `result` = 42, `done` at T+65 (macro off). With the macro on, `done` arrives at T+5.
- MUL `rs1` = 0xFFFF_FFFF_FFFF_FFFF, `rs2` = 2 -> `result` = 0xFFFF_FFFF_FFFF_FFFE (wraparound).
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0001 -> 1, and REMU on the same operands -> 0x7FFF_FFFF_FFFF_FFFE (exercises the `ovf` path).
- DIVU 1234/0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 1234/0 -> 1234. Macro on: `done` at T+2.
- Start DIVU; pulse `start` with new operands at T+10 -> ignored, original result returned. Assert `reset` at T+20 -> next cycle `busy` = 0, `result` = 0, and no `done` pulse afterward.
- `op` = 11 -> `result` = 0, `done` at T+2. Every RUN cycle checks that `alu_op` is 4'b0010 for MUL and 4'b0110 for DIVU/REMU.
